// File: rtl/mca_pkg.sv
// Shared state encoding and constants for the MCA histogram core.
package mca_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int          NUM_CH    = 1024;
  localparam int          DRAIN_LEN = 2;
  localparam logic [31:0] COUNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/hist_ram.sv
// Channel-count memory: port A sync read plus write, port B sync read-only.
// One-cycle read latency on both ports; old data is returned on a same-address read/write.
module hist_ram
  import mca_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic [DATA_W-1:0] a_q,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    a_q <= mem[a_raddr];
  end

  // Only the host-facing output register is reset so channel_count starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_q <= '0;
    else        b_q <= mem[b_addr];
  end

endmodule

// File: rtl/mca_histogram.sv
// MCA histogram: synchronised start/pause/clear commands, 1 event/clk saturating increment
// pipeline with forwarding, automatic RAM sweep on clear and reset, registered host read port.
module mca_histogram
  import mca_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_clear,
  input  logic              event_valid,
  input  logic [ADDR_W-1:0] event_channel,
  output logic              event_ready,
  input  logic [ADDR_W-1:0] channel_address,
  output logic [DATA_W-1:0] channel_count,
  output logic              running,
  output logic              clearing,
  output logic [31:0]       total_events,
  output logic [15:0]       dropped_events
);

  localparam logic [DATA_W-1:0] SAT     = {DATA_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_CH = {ADDR_W{1'b1}};

  logic [2:0] cmd_raw;
  logic [2:0] cmd_pulse;
  logic       start_p, pause_p, clear_p;

  assign cmd_raw = {cmd_clear, cmd_pause, cmd_start};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    logic [SYNC_STAGES:0] sr;
    logic                 pulse;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr    <= '0;
        pulse <= 1'b0;
      end else begin
        sr    <= {sr[SYNC_STAGES-1:0], cmd_raw[g]};
        pulse <= sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
      end
    end
    assign cmd_pulse[g] = pulse;
  end

  assign start_p = cmd_pulse[0];
  assign pause_p = cmd_pulse[1];
  assign clear_p = cmd_pulse[2];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q;
  logic [1:0]        drain_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_p) state_d = DRAIN;
               else if (start_p && !pause_p) state_d = RUN;
      RUN:     if (clear_p) state_d = DRAIN;
               else if (pause_p) state_d = IDLE;
      DRAIN:   if (drain_cnt_q == 2'(DRAIN_LEN - 1)) state_d = CLEAR;
      CLEAR:   if (sweep_q == LAST_CH) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      sweep_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 2'd1 : 2'd0;
      sweep_q     <= (state_q == CLEAR) ? sweep_q + 1'b1 : '0;
    end
  end

  assign event_ready = (state_q == RUN);
  assign running     = (state_q == RUN);
  assign clearing    = (state_q == DRAIN) || (state_q == CLEAR);

  logic              accept, sweeping, enter_drain;
  logic              s1_vld, s2_vld;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [DATA_W-1:0] s2_dat, ram_a_q, base, incd;

  assign accept      = event_valid && event_ready;
  assign sweeping    = (state_q == CLEAR);
  assign enter_drain = (state_d == DRAIN) && (state_q != DRAIN);

  // The RAM still returns pre-write data for the previous event on this channel.
  assign base = (s2_vld && (s2_addr == s1_addr)) ? s2_dat : ram_a_q;
  assign incd = (base == SAT) ? base : base + DATA_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_dat  <= '0;
    end else begin
      s1_vld  <= accept;
      s1_addr <= event_channel;
      s2_vld  <= s1_vld;
      s2_addr <= s1_addr;
      s2_dat  <= incd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_events   <= '0;
      dropped_events <= '0;
    end else if (enter_drain) begin
      total_events   <= '0;
      dropped_events <= '0;
    end else begin
      if (accept) total_events <= total_events + 32'd1;
      if (event_valid && !event_ready && dropped_events != 16'hFFFF)
        dropped_events <= dropped_events + 16'd1;
    end
  end

  hist_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raddr (event_channel),
    .a_q     (ram_a_q),
    .a_we    (sweeping || s1_vld),
    .a_waddr (sweeping ? sweep_q : s1_addr),
    .a_wdata (sweeping ? '0 : incd),
    .b_addr  (channel_address),
    .b_q     (channel_count)
  );

endmodule

// File: tb/tb_mca_histogram.sv
// Directed bench for mca_histogram: reset sweep, counting, forwarding, pause, clear priority, saturation.
module tb_mca_histogram;
  import mca_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, cmd_start, cmd_pause, cmd_clear, event_valid;
  logic [9:0]  event_channel, channel_address;
  logic        event_ready, running, clearing;
  logic [31:0] channel_count, total_events;
  logic [15:0] dropped_events;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  mca_histogram #(.ADDR_W(10), .DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_start       (cmd_start),
    .cmd_pause       (cmd_pause),
    .cmd_clear       (cmd_clear),
    .event_valid     (event_valid),
    .event_channel   (event_channel),
    .event_ready     (event_ready),
    .channel_address (channel_address),
    .channel_count   (channel_count),
    .running         (running),
    .clearing        (clearing),
    .total_events    (total_events),
    .dropped_events  (dropped_events)
  );

  task automatic ev(input logic [9:0] ch, input logic v);
    @(posedge clk); #1;
    event_valid   = v;
    event_channel = ch;
  endtask

  task automatic send_cmd(input logic s, input logic p, input logic c);
    @(posedge clk); #1;
    cmd_start = s; cmd_pause = p; cmd_clear = c;
    repeat (2) @(posedge clk);
    #1;
    cmd_start = 1'b0; cmd_pause = 1'b0; cmd_clear = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] c);
    @(posedge clk); #1;
    channel_address = a;
    @(posedge clk);
    @(negedge clk);
    c = channel_count;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (clearing && cycles < 1200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] c;
    int n;
    rst_n = 1'b0; cmd_start = 0; cmd_pause = 0; cmd_clear = 0;
    event_valid = 0; event_channel = '0; channel_address = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (event_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", event_ready); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL rst_running: got %b want 0", running); else n_pass++;
    n_checks++; if (clearing !== 1'b1) $display("FAIL rst_clearing: got %b want 1", clearing); else n_pass++;
    n_checks++; if (channel_count !== 32'd0) $display("FAIL rst_count: got %h want 0", channel_count); else n_pass++;
    n_checks++; if (total_events !== 32'd0) $display("FAIL rst_total: got %0d want 0", total_events); else n_pass++;
    n_checks++; if (dropped_events !== 16'd0) $display("FAIL rst_dropped: got %0d want 0", dropped_events); else n_pass++;
    rst_n = 1'b1;
    n = clearing ? 1 : 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!clearing) break;
      n++;
    end
    n_checks++; if (n !== 1024) $display("FAIL sweep_len: got %0d cycles want 1024", n); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL idle_after_sweep: running %b want 0", running); else n_pass++;
    rd(10'd0, c);
    n_checks++; if (c !== 32'd0) $display("FAIL rd0: got %h want 0", c); else n_pass++;
    rd(10'd511, c);
    n_checks++; if (c !== 32'd0) $display("FAIL rd511: got %h want 0", c); else n_pass++;
    rd(10'd1023, c);
    n_checks++; if (c !== 32'd0) $display("FAIL rd1023: got %h want 0", c); else n_pass++;
  endtask

  task automatic test_run;
    logic [31:0] c;
    send_cmd(1'b1, 1'b0, 1'b0);
    n_checks++; if (running !== 1'b1) $display("FAIL run_state: running %b want 1", running); else n_pass++;
    for (int i = 0; i < 5; i++) ev(10'd7, 1'b1);
    ev(10'd0, 1'b0);
    rd(10'd7, c);
    n_checks++; if (c !== 32'd5) $display("FAIL ch7: got %0d want 5", c); else n_pass++;
    n_checks++; if (total_events !== 32'd5) $display("FAIL run_total: got %0d want 5", total_events); else n_pass++;
    n_checks++; if (dropped_events !== 16'd0) $display("FAIL run_dropped: got %0d want 0", dropped_events); else n_pass++;
  endtask

  task automatic test_forward;
    logic [31:0] c;
    ev(10'd3, 1'b1); ev(10'd4, 1'b1); ev(10'd3, 1'b1); ev(10'd4, 1'b1);
    ev(10'd0, 1'b0);
    ev(10'd3, 1'b1);
    ev(10'd0, 1'b0);
    rd(10'd3, c);
    n_checks++; if (c !== 32'd3) $display("FAIL fwd_ch3: got %0d want 3", c); else n_pass++;
    rd(10'd4, c);
    n_checks++; if (c !== 32'd2) $display("FAIL fwd_ch4: got %0d want 2", c); else n_pass++;
    rd(10'd7, c);
    n_checks++; if (c !== 32'd5) $display("FAIL fwd_ch7: got %0d want 5", c); else n_pass++;
    n_checks++; if (total_events !== 32'd10) $display("FAIL fwd_total: got %0d want 10", total_events); else n_pass++;
  endtask

  task automatic test_pause;
    logic [31:0] c;
    send_cmd(1'b0, 1'b1, 1'b0);
    n_checks++; if (event_ready !== 1'b0) $display("FAIL pause_ready: got %b want 0", event_ready); else n_pass++;
    for (int i = 0; i < 10; i++) ev(10'd5, 1'b1);
    ev(10'd0, 1'b0);
    rd(10'd5, c);
    n_checks++; if (c !== 32'd0) $display("FAIL pause_ch5: got %0d want 0", c); else n_pass++;
    rd(10'd3, c);
    n_checks++; if (c !== 32'd3) $display("FAIL pause_ch3: got %0d want 3", c); else n_pass++;
    n_checks++; if (dropped_events !== 16'd10) $display("FAIL pause_dropped: got %0d want 10", dropped_events); else n_pass++;
    n_checks++; if (total_events !== 32'd10) $display("FAIL pause_total: got %0d want 10", total_events); else n_pass++;
  endtask

  task automatic test_clear_priority;
    logic [31:0] c;
    int cyc;
    send_cmd(1'b1, 1'b0, 1'b0);
    n_checks++; if (running !== 1'b1) $display("FAIL restart: running %b want 1", running); else n_pass++;
    send_cmd(1'b1, 1'b0, 1'b1);
    n_checks++; if (clearing !== 1'b1) $display("FAIL clr_active: clearing %b want 1", clearing); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL clr_running: got %b want 0", running); else n_pass++;
    n_checks++; if (total_events !== 32'd0) $display("FAIL clr_total: got %0d want 0", total_events); else n_pass++;
    n_checks++; if (dropped_events !== 16'd0) $display("FAIL clr_dropped: got %0d want 0", dropped_events); else n_pass++;
    wait_idle(cyc);
    n_checks++; if (clearing !== 1'b0) $display("FAIL clr_timeout: clearing %b after %0d cycles want 0", clearing, cyc); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL clr_idle: running %b want 0", running); else n_pass++;
    rd(10'd3, c);
    n_checks++; if (c !== 32'd0) $display("FAIL clr_ch3: got %0d want 0", c); else n_pass++;
    rd(10'd4, c);
    n_checks++; if (c !== 32'd0) $display("FAIL clr_ch4: got %0d want 0", c); else n_pass++;
    rd(10'd7, c);
    n_checks++; if (c !== 32'd0) $display("FAIL clr_ch7: got %0d want 0", c); else n_pass++;
  endtask

  task automatic test_saturate;
    logic [31:0] c;
    dut.u_ram.mem[9] = 32'hFFFF_FFFE;
    send_cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ev(10'd9, 1'b1);
    ev(10'd0, 1'b0);
    rd(10'd9, c);
    n_checks++; if (c !== COUNT_SAT) $display("FAIL sat_ch9: got %h want %h", c, COUNT_SAT); else n_pass++;
    rd(10'd8, c);
    n_checks++; if (c !== 32'd0) $display("FAIL sat_ch8: got %h want 0", c); else n_pass++;
    n_checks++; if (total_events !== 32'd3) $display("FAIL sat_total: got %0d want 3", total_events); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_forward();
    test_pause();
    test_clear_priority();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
